// File: rtl/hash_func_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_func_pkg
//  Description : Shared constants and state encoding for the two-hash
//                generator (hash_func) and its sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package hash_func_pkg;

    // Default datapath widths
    localparam int DEF_KEY_W  = 32;
    localparam int DEF_HASH_W = 32;

    // Default moduli for the two hash functions
    localparam int DEF_MOD1 = 11;
    localparam int DEF_MOD2 = 11;

    // Moduli are below 2^16, so a shifted partial remainder (< 2*MOD)
    // always fits in 17 bits.
    localparam int REM_W = 17;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV1 = 2'd1;
    localparam logic [1:0] S_DIV2 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hash_func_if.sv
`default_nettype none
// ============================================================================
//  Module      : hash_func_if
//  Description : Key-in / hash-out valid-ready bundle for hash_func.
//                key_is_empty exists only when HASH_FUNC_EMPTY_FLAG_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hash_func_if
    import hash_func_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int HASH_W = DEF_HASH_W
);
    logic              in_valid;
    logic              in_ready;
    logic [KEY_W-1:0]  key;
    logic              out_valid;
    logic              out_ready;
    logic [HASH_W-1:0] hash1;
    logic [HASH_W-1:0] hash2;
`ifdef HASH_FUNC_EMPTY_FLAG_EN
    logic              key_is_empty;

    modport master (
        output in_valid, key, out_ready,
        input  in_ready, out_valid, hash1, hash2, key_is_empty
    );
    modport slave (
        input  in_valid, key, out_ready,
        output in_ready, out_valid, hash1, hash2, key_is_empty
    );
`else
    modport master (
        output in_valid, key, out_ready,
        input  in_ready, out_valid, hash1, hash2
    );
    modport slave (
        input  in_valid, key, out_ready,
        output in_ready, out_valid, hash1, hash2
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hash_func_seq_mod_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mod_div
//  Description : 1-bit-per-cycle restoring divider, MSB first. start loads a
//                new dividend/divisor (and has priority over stepping, so a
//                new division may be chained on the done cycle). done is high
//                during the final step; quotient/remainder then show the
//                result that step produces.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mod_div
    import hash_func_pkg::*;
#(
    parameter int DIV_W = DEF_KEY_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [DIV_W-1:0] dividend,
    input  wire logic [REM_W-1:0] divisor,
    output logic                  done,
    output logic [DIV_W-1:0]      quotient,
    output logic [REM_W-1:0]      remainder
);
    localparam int              CNT_W     = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

    // Stored remainder is always below the divisor (< 2^16), one bit
    // narrower than the shifted partial remainder.
    logic [REM_W-2:0] rem_q, rem_d;
    logic [REM_W-1:0] dsr_q, dsr_d;
    logic [DIV_W-1:0] dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] rem_step;
    logic             q_bit;

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_shift = {rem_q, dvd_q[DIV_W-1]};
        q_bit     = (rem_shift >= dsr_q);
        rem_step  = q_bit ? (rem_shift - dsr_q) : rem_shift;
        quotient  = {dvd_q[DIV_W-2:0], q_bit};
        remainder = rem_step;
        done      = busy_q && (cnt_q == LAST_STEP);
    end

    // Next-state: load on start, otherwise advance while busy
    always_comb begin
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        dvd_d  = dvd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            dsr_d  = divisor;
            dvd_d  = dividend;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step[REM_W-2:0];
            dvd_d = quotient;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            dvd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hash_func.sv
`default_nettype none
// ============================================================================
//  Module      : hash_func
//  Description : Iterative two-hash generator for the cuckoo store.
//                hash1 = key mod MOD1, hash2 = (key div MOD1) mod MOD2,
//                computed by one shared sequential divider, 2*KEY_W edges
//                from accept to out_valid. One key in flight at a time.
//                Optional feature macro: HASH_FUNC_EMPTY_FLAG_EN adds
//                key_is_empty (accepted key was the empty-slot marker 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_func
    import hash_func_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int HASH_W = DEF_HASH_W,
    parameter int MOD1   = DEF_MOD1,
    parameter int MOD2   = DEF_MOD2
) (
    input  wire logic  clock,
    input  wire logic  reset,
    hash_func_if.slave bus
);
    localparam logic [REM_W-1:0] MOD1_C = REM_W'(MOD1);
    localparam logic [REM_W-1:0] MOD2_C = REM_W'(MOD2);

    state_t            state_q, state_d;
    logic [REM_W-1:0]  r1_q, r1_d;
    logic [HASH_W-1:0] hash1_q, hash1_d;
    logic [HASH_W-1:0] hash2_q, hash2_d;

    logic              div_start;
    logic [KEY_W-1:0]  div_dividend;
    logic [REM_W-1:0]  div_divisor;
    logic              div_done;
    logic [KEY_W-1:0]  div_quo;
    logic [REM_W-1:0]  div_rem;

    seq_mod_div #(
        .DIV_W (KEY_W)
    ) u_div (
        .clk       (clock),
        .rst       (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Controller: accept key, chain the second division on the quotient
    always_comb begin
        state_d      = state_q;
        r1_d         = r1_q;
        hash1_d      = hash1_q;
        hash2_d      = hash2_q;
        div_start    = 1'b0;
        div_dividend = bus.key;
        div_divisor  = MOD1_C;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    div_start = 1'b1;
                    state_d   = S_DIV1;
                end
            end
            S_DIV1: begin
                if (div_done) begin
                    r1_d         = div_rem;
                    div_start    = 1'b1;
                    div_dividend = div_quo;
                    div_divisor  = MOD2_C;
                    state_d      = S_DIV2;
                end
            end
            S_DIV2: begin
                if (div_done) begin
                    hash1_d = HASH_W'(r1_q);
                    hash2_d = HASH_W'(div_rem);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller and result registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            r1_q    <= '0;
            hash1_q <= '0;
            hash2_q <= '0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            hash1_q <= hash1_d;
            hash2_q <= hash2_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.hash1     = hash1_q;
    assign bus.hash2     = hash2_q;

`ifdef HASH_FUNC_EMPTY_FLAG_EN
    logic key_zero_q, key_zero_d;
    logic empty_q, empty_d;

    // Remember a zero key at accept; raise the flag alongside out_valid
    always_comb begin
        key_zero_d = key_zero_q;
        empty_d    = empty_q;
        if (state_q == S_IDLE && bus.in_valid) begin
            key_zero_d = (bus.key == '0);
        end
        if (state_q == S_DIV2 && div_done) begin
            empty_d = key_zero_q;
        end
        if (state_q == S_DONE && bus.out_ready) begin
            empty_d = 1'b0;
        end
    end

    // Empty-flag registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            key_zero_q <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            key_zero_q <= key_zero_d;
            empty_q    <= empty_d;
        end
    end

    assign bus.key_is_empty = empty_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hash_func.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash_func
//  Description : Self-checking bench for hash_func. A per-cycle monitor
//                compares the DUT to a cycle-level model built from the
//                arithmetic definition (mod/div) and the fixed 2*KEY_W
//                latency; directed cases pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_func;
    import hash_func_pkg::*;

    localparam int KEY_W  = 32;
    localparam int HASH_W = 32;
    localparam int MOD1   = 11;
    localparam int MOD2   = 11;
    localparam int LAT    = 2 * KEY_W;
    localparam int TMO    = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_func_if #(.KEY_W(KEY_W), .HASH_W(HASH_W)) bus ();

    hash_func #(
        .KEY_W  (KEY_W),
        .HASH_W (HASH_W),
        .MOD1   (MOD1),
        .MOD2   (MOD2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    function automatic logic [HASH_W-1:0] ref_h1(input logic [KEY_W-1:0] k);
        longint unsigned kk = 64'(k);
        return HASH_W'(kk % MOD1);
    endfunction

    function automatic logic [HASH_W-1:0] ref_h2(input logic [KEY_W-1:0] k);
        longint unsigned kk = 64'(k);
        return HASH_W'((kk / MOD1) % MOD2);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cycle-level model and per-cycle compare --------------
    // ph: 0 idle, 1 computing (n = edges since accept), 2 result held
    int                ph    = 0;
    int                n     = 0;
    logic [KEY_W-1:0]  mkey  = '0;
    logic [HASH_W-1:0] m_h1  = '0;
    logic [HASH_W-1:0] m_h2  = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  64'(bus.in_ready),  64'(ph == 0));
            check("out_valid", 64'(bus.out_valid), 64'(ph == 2));
            check("hash1",     64'(bus.hash1),     64'(m_h1));
            check("hash2",     64'(bus.hash2),     64'(m_h2));
`ifdef HASH_FUNC_EMPTY_FLAG_EN
            check("key_is_empty", 64'(bus.key_is_empty), 64'(ph == 2 && mkey == '0));
`endif
        end
        // Predict the effect of the coming rising edge
        if (rst) begin
            ph   = 0;
            m_h1 = '0;
            m_h2 = '0;
        end else begin
            case (ph)
                0: if (bus.in_valid) begin
                    ph   = 1;
                    n    = 0;
                    mkey = bus.key;
                end
                1: begin
                    n++;
                    if (n == LAT) begin
                        ph   = 2;
                        m_h1 = ref_h1(mkey);
                        m_h2 = ref_h2(mkey);
                    end
                end
                default: if (bus.out_ready) ph = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick(input int c = 1);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [KEY_W-1:0] k);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.key      = k;
        while (!bus.in_ready && t < TMO) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            check("accept timeout", 64'(bus.in_ready), 64'd1);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.key      = $urandom;
    endtask

    task automatic await_result(input string nm, input logic [HASH_W-1:0] e1,
                                input logic [HASH_W-1:0] e2, input bit e_empty,
                                input int exp_lat);
        int t = 0;
        while (!bus.out_valid && t < TMO) begin
            tick();
            t++;
        end
        if (!bus.out_valid) begin
            check({nm, " out_valid timeout"}, 64'(bus.out_valid), 64'd1);
            return;
        end
        if (exp_lat > 0) check({nm, " latency"}, 64'(t), 64'(exp_lat));
        check({nm, " hash1"}, 64'(bus.hash1), 64'(e1));
        check({nm, " hash2"}, 64'(bus.hash2), 64'(e2));
`ifdef HASH_FUNC_EMPTY_FLAG_EN
        check({nm, " key_is_empty"}, 64'(bus.key_is_empty), 64'(e_empty));
`else
        if (e_empty) vectors += 0;
`endif
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle after take", 64'(bus.in_ready), 64'd1);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.key       = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset hash1",     64'(bus.hash1),     64'd0);
        check("reset hash2",     64'(bus.hash2),     64'd0);
        rst = 1'b0;
        tick();

        // Directed keys with hand-computed results
        send(32'd20);          await_result("k20",  9, 1, 1'b0, LAT); take();
        send(32'd100);         await_result("k100", 1, 9, 1'b0, LAT); take();
        send(32'd121);         await_result("k121", 0, 0, 1'b0, LAT); take();
        send(32'hFFFF_FFFF);   await_result("kmax", 3, 5, 1'b0, LAT); take();
        send(32'd0);           await_result("k0",   0, 0, 1'b1, LAT); take();

        // Backpressure: result held, in_valid pulses ignored
        send(32'd20);
        await_result("bp", 9, 1, 1'b0, LAT);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.key      = 32'd77;
            tick();
            check("bp hold hash1", 64'(bus.hash1),     64'd9);
            check("bp hold hash2", 64'(bus.hash2),     64'd1);
            check("bp in_ready",   64'(bus.in_ready),  64'd0);
            check("bp out_valid",  64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        take();

        // Reset in the middle of the second division
        send(32'd20);
        tick(39);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);
        tick(80);
        send(32'd100);         await_result("after rst", 1, 9, 1'b0, LAT); take();

        // Back-to-back with out_ready held high
        bus.out_ready = 1'b1;
        send(32'd20);  await_result("b2b 20",  9, 1, 1'b0, LAT); tick();
        send(32'd100); await_result("b2b 100", 1, 9, 1'b0, LAT); tick();
        send(32'd121); await_result("b2b 121", 0, 0, 1'b0, LAT); tick();
        bus.out_ready = 1'b0;

        // Randomized keys, random consumer readiness and stray in_valid
        for (int k = 0; k < 40; k++) begin
            logic [KEY_W-1:0] rk;
            int               t;
            bit               hs;
            case ($urandom_range(0, 3))
                0:       rk = KEY_W'($urandom_range(0, 300));
                1:       rk = 32'hFFFF_FFFF - KEY_W'($urandom_range(0, 15));
                2:       rk = (k % 8 == 0) ? 32'd0 : KEY_W'($urandom);
                default: rk = KEY_W'($urandom);
            endcase
            send(rk);
            t  = 0;
            hs = 1'b0;
            while (!hs && t < TMO) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.in_valid  = (bus.out_valid) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.key       = $urandom;
                hs = bus.out_valid && bus.out_ready;
                tick();
                t++;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            if (!hs) check("random handshake timeout", 64'(hs), 64'd1);
        end

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
